// File: rtl/issue_decoder_q.sv
// issue_decoder_q: decode/issue stage between the fetcher and the RS/LSB/RoB.
// Fetched instructions are buffered in a small circular queue. The head entry
// is decoded combinationally and issued at most once per cycle. RS-bound and
// LSB-bound instructions stall independently. A static next-PC prediction is
// made at issue time. A redirect discards the younger queued entries, which are
// on the wrong path.

module issue_decoder_q #(
  parameter int XLEN      = 32,
  parameter int ROB_ID_W  = 4,
  parameter int IQ_DEPTH  = 4,
  parameter int PRED_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      instr_valid,
  input  logic [31:0]               instr_in,
  input  logic [XLEN-1:0]           instr_addr_in,
  output logic                      iq_full,
  output logic [$clog2(IQ_DEPTH):0] iq_count,
  input  logic                      rob_full,
  input  logic                      rs_full,
  input  logic                      lsb_full,
  output logic [4:0]                reg_id1,
  output logic [4:0]                reg_id2,
  input  logic [XLEN-1:0]           reg_value1_in,
  input  logic [XLEN-1:0]           reg_value2_in,
  input  logic                      has_dep1_in,
  input  logic                      has_dep2_in,
  input  logic [ROB_ID_W-1:0]       v_rob_id1_in,
  input  logic [ROB_ID_W-1:0]       v_rob_id2_in,
  input  logic [ROB_ID_W-1:0]       rd_rob_id_in,
  output logic                      instr_issued,
  output logic [31:0]               instr_out,
  output logic [XLEN-1:0]           instr_addr_out,
  output logic [2:0]                op_out,
  output logic [6:0]                instr_type_out,
  output logic [XLEN-1:0]           reg_value1_out,
  output logic [XLEN-1:0]           reg_value2_out,
  output logic                      has_dep1_out,
  output logic                      has_dep2_out,
  output logic [ROB_ID_W-1:0]       v_rob_id1_out,
  output logic [ROB_ID_W-1:0]       v_rob_id2_out,
  output logic [ROB_ID_W-1:0]       rd_rob_id_out,
  output logic [XLEN-1:0]           imm,
  output logic [4:0]                rd,
  output logic                      predict_valid,
  output logic [XLEN-1:0]           predict_pc
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Base-ISA major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  // Immediate extraction for every base format. R-type and unknown opcodes give 0.
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ins);
    logic [31:0] raw;
    raw = 32'd0;
    case (ins[6:0])
      OP_LUI, OP_AUIPC:          raw = {ins[31:12], 12'd0};
      OP_JAL:                    raw = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      OP_JALR, OP_LOAD, OP_IMM:  raw = {{21{ins[31]}}, ins[30:20]};
      OP_STORE:                  raw = {{21{ins[31]}}, ins[30:25], ins[11:7]};
      OP_BRANCH:                 raw = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      default:                   raw = 32'd0;
    endcase
    return XLEN'($signed(raw));
  endfunction

  // True when the opcode reads a second source register
  function automatic logic uses_rs2(input logic [6:0] opc);
    logic r;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM: r = 1'b0;
      default:                                            r = 1'b1;
    endcase
    return r;
  endfunction

  // True when the opcode writes a destination register
  function automatic logic writes_rd(input logic [6:0] opc);
    logic r;
    case (opc)
      OP_BRANCH, OP_STORE: r = 1'b0;
      default:             r = 1'b1;
    endcase
    return r;
  endfunction

  // Queue storage and pointers
  logic [31:0]      iq_instr_r [IQ_DEPTH];
  logic [XLEN-1:0]  iq_addr_r  [IQ_DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  // Head decode
  logic [31:0]      head_instr_s;
  logic [XLEN-1:0]  head_addr_s;
  logic [6:0]       opcode_s;
  logic [XLEN-1:0]  imm_s;
  logic             has_rs2_s;
  logic             has_rd_s;
  logic             head_valid_s;
  logic             is_mem_s;
  logic             unit_ok_s;
  logic             jalr_block_s;
  logic             issue_s;
  logic             push_s;
  logic             pred_taken_s;
  logic [XLEN-1:0]  pc_plus4_s;
  logic [XLEN-1:0]  jalr_sum_s;
  logic [XLEN-1:0]  target_s;
  logic             redirect_s;

  assign head_instr_s = iq_instr_r[head_r];
  assign head_addr_s  = iq_addr_r[head_r];
  assign opcode_s     = head_instr_s[6:0];
  assign imm_s        = imm_gen(head_instr_s);
  assign has_rs2_s    = uses_rs2(opcode_s);
  assign has_rd_s     = writes_rd(opcode_s);
  assign head_valid_s = (count_r != {CNT_W{1'b0}});
  assign pc_plus4_s   = head_addr_s + XLEN'(4);
  assign jalr_sum_s   = reg_value1_in + imm_s;

  assign reg_id1  = head_instr_s[19:15];
  assign reg_id2  = head_instr_s[24:20];
  assign iq_full  = (count_r == CNT_W'(IQ_DEPTH));
  assign iq_count = count_r;

  // Pushing is blocked whenever the queue is full, even if the head pops this cycle
  assign push_s = instr_valid & ~iq_full;

  // Issue qualification: RoB space, target-unit space, and a known JALR base
  always_comb begin
    is_mem_s     = 1'b0;
    unit_ok_s    = 1'b0;
    jalr_block_s = 1'b0;
    issue_s      = 1'b0;
    if ((opcode_s == OP_LOAD) || (opcode_s == OP_STORE)) begin
      is_mem_s = 1'b1;
    end else begin
      is_mem_s = 1'b0;
    end
    if (is_mem_s) begin
      unit_ok_s = ~lsb_full;
    end else begin
      unit_ok_s = ~rs_full;
    end
    if (opcode_s == OP_JALR) begin
      jalr_block_s = has_dep1_in;
    end else begin
      jalr_block_s = 1'b0;
    end
    issue_s = head_valid_s & ~rob_full & unit_ok_s & ~jalr_block_s;
  end

  // Static branch direction: always taken, or backward-taken/forward-not-taken
  always_comb begin
    pred_taken_s = 1'b1;
    if (PRED_MODE == 0) begin
      pred_taken_s = 1'b1;
    end else begin
      pred_taken_s = imm_s[XLEN-1];
    end
  end

  // Next-PC target of the head instruction and redirect decision
  always_comb begin
    target_s = pc_plus4_s;
    case (opcode_s)
      OP_JAL:    target_s = head_addr_s + imm_s;
      OP_JALR:   target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
      OP_BRANCH: begin
        if (pred_taken_s) begin
          target_s = head_addr_s + imm_s;
        end else begin
          target_s = pc_plus4_s;
        end
      end
      default:   target_s = pc_plus4_s;
    endcase
    redirect_s = (target_s != pc_plus4_s);
  end

  // Queue state: push at tail, pop at head, wrong-path squash on redirect
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < IQ_DEPTH; i++) begin
        iq_instr_r[i] <= 32'd0;
        iq_addr_r[i]  <= {XLEN{1'b0}};
      end
    end else if (!rdy) begin
      head_r  <= head_r;
      tail_r  <= tail_r;
      count_r <= count_r;
    end else if (flush || (issue_s && redirect_s)) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        iq_instr_r[tail_r] <= instr_in;
        iq_addr_r[tail_r]  <= instr_addr_in;
        tail_r             <= tail_r + PTR_W'(1);
      end
      if (issue_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(issue_s);
    end
  end

  // Issue outputs: pulses clear every cycle, data registers load only on issue
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_issued   <= 1'b0;
      instr_out      <= 32'd0;
      instr_addr_out <= {XLEN{1'b0}};
      op_out         <= 3'd0;
      instr_type_out <= 7'd0;
      reg_value1_out <= {XLEN{1'b0}};
      reg_value2_out <= {XLEN{1'b0}};
      has_dep1_out   <= 1'b0;
      has_dep2_out   <= 1'b0;
      v_rob_id1_out  <= {ROB_ID_W{1'b0}};
      v_rob_id2_out  <= {ROB_ID_W{1'b0}};
      rd_rob_id_out  <= {ROB_ID_W{1'b0}};
      imm            <= {XLEN{1'b0}};
      rd             <= 5'd0;
      predict_valid  <= 1'b0;
      predict_pc     <= {XLEN{1'b0}};
    end else if (!rdy) begin
      instr_issued  <= instr_issued;
      predict_valid <= predict_valid;
    end else if (flush) begin
      instr_issued  <= 1'b0;
      predict_valid <= 1'b0;
    end else begin
      instr_issued  <= issue_s;
      predict_valid <= issue_s & redirect_s;
      if (issue_s) begin
        instr_out      <= head_instr_s;
        instr_addr_out <= head_addr_s;
        op_out         <= head_instr_s[14:12];
        instr_type_out <= opcode_s;
        reg_value1_out <= reg_value1_in;
        has_dep1_out   <= has_dep1_in;
        v_rob_id1_out  <= v_rob_id1_in;
        rd_rob_id_out  <= rd_rob_id_in;
        imm            <= imm_s;
        if (has_rs2_s) begin
          reg_value2_out <= reg_value2_in;
          has_dep2_out   <= has_dep2_in;
          v_rob_id2_out  <= v_rob_id2_in;
        end else begin
          reg_value2_out <= imm_s;
          has_dep2_out   <= 1'b0;
          v_rob_id2_out  <= {ROB_ID_W{1'b0}};
        end
        if (has_rd_s) begin
          rd <= head_instr_s[11:7];
        end else begin
          rd <= 5'd0;
        end
        if (redirect_s) begin
          predict_pc <= target_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_decoder_q.sv
// Scoreboard bench for issue_decoder_q (IQ_DEPTH=4, PRED_MODE=1).
// Expected issue records are queued when the instruction is pushed; a monitor
// on the falling edge pops and compares whenever a fresh issue pulse appears.

module tb_issue_decoder_q;

  localparam logic [3:0] ID1   = 4'h2;
  localparam logic [3:0] ID2   = 4'h5;
  localparam logic [3:0] ROBID = 4'h7;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, instr_valid;
  logic [31:0] instr_in, instr_addr_in;
  logic        iq_full;
  logic [2:0]  iq_count;
  logic        rob_full, rs_full, lsb_full;
  logic [4:0]  reg_id1, reg_id2;
  logic [31:0] reg_value1_in, reg_value2_in;
  logic        has_dep1_in, has_dep2_in;
  logic [3:0]  v_rob_id1_in, v_rob_id2_in, rd_rob_id_in;
  logic        instr_issued;
  logic [31:0] instr_out, instr_addr_out;
  logic [2:0]  op_out;
  logic [6:0]  instr_type_out;
  logic [31:0] reg_value1_out, reg_value2_out;
  logic        has_dep1_out, has_dep2_out;
  logic [3:0]  v_rob_id1_out, v_rob_id2_out, rd_rob_id_out;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic        predict_valid;
  logic [31:0] predict_pc;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  op;
    logic [6:0]  typ;
    logic [31:0] v1;
    logic        d1;
    logic [3:0]  id1;
    logic [31:0] v2;
    logic        d2;
    logic [3:0]  id2;
    logic [3:0]  robid;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        pv;
    logic [31:0] ppc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_exp, mon_act;
  logic [31:0] last_ppc = 32'd0;
  logic        edge_rdy = 1'b0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_issue  = 0;

  issue_decoder_q #(.XLEN(32), .ROB_ID_W(4), .IQ_DEPTH(4), .PRED_MODE(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .instr_valid(instr_valid), .instr_in(instr_in), .instr_addr_in(instr_addr_in),
    .iq_full(iq_full), .iq_count(iq_count),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .reg_id1(reg_id1), .reg_id2(reg_id2),
    .reg_value1_in(reg_value1_in), .reg_value2_in(reg_value2_in),
    .has_dep1_in(has_dep1_in), .has_dep2_in(has_dep2_in),
    .v_rob_id1_in(v_rob_id1_in), .v_rob_id2_in(v_rob_id2_in), .rd_rob_id_in(rd_rob_id_in),
    .instr_issued(instr_issued), .instr_out(instr_out), .instr_addr_out(instr_addr_out),
    .op_out(op_out), .instr_type_out(instr_type_out),
    .reg_value1_out(reg_value1_out), .reg_value2_out(reg_value2_out),
    .has_dep1_out(has_dep1_out), .has_dep2_out(has_dep2_out),
    .v_rob_id1_out(v_rob_id1_out), .v_rob_id2_out(v_rob_id2_out),
    .rd_rob_id_out(rd_rob_id_out), .imm(imm), .rd(rd),
    .predict_valid(predict_valid), .predict_pc(predict_pc)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Remember whether the DUT was enabled at the last rising edge
  always @(posedge clk) edge_rdy <= rdy;

  // Monitor: every fresh issue pulse must match the oldest expected record
  always @(negedge clk) begin
    if (edge_rdy && instr_issued === 1'b1) begin
      n_checks++;
      n_issue++;
      if (sb.size() == 0) begin
        $display("FAIL spurious_issue: got issue of 0x%08h at pc 0x%08h expected no issue", instr_out, instr_addr_out);
      end else begin
        mon_exp       = sb.pop_front();
        mon_act.instr = instr_out;      mon_act.pc    = instr_addr_out;
        mon_act.op    = op_out;         mon_act.typ   = instr_type_out;
        mon_act.v1    = reg_value1_out; mon_act.d1    = has_dep1_out;
        mon_act.id1   = v_rob_id1_out;  mon_act.v2    = reg_value2_out;
        mon_act.d2    = has_dep2_out;   mon_act.id2   = v_rob_id2_out;
        mon_act.robid = rd_rob_id_out;  mon_act.imm   = imm;
        mon_act.rd    = rd;             mon_act.pv    = predict_valid;
        mon_act.ppc   = predict_pc;
        if (mon_act === mon_exp) n_pass++;
        else $display("FAIL issue%0d: got %h expected %h", n_issue, mon_act, mon_exp);
      end
    end
  end

  // Abort guard so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_issue(input logic [31:0] ins, input logic [31:0] pc, input logic [2:0] op,
                              input logic [6:0] typ, input logic [31:0] v1, input logic d1,
                              input logic [31:0] v2, input logic d2, input logic [3:0] id2,
                              input logic [31:0] im, input logic [4:0] rdx, input logic pv,
                              input logic [31:0] ppc);
    exp_t e;
    if (pv) last_ppc = ppc;
    e = '{instr: ins, pc: pc, op: op, typ: typ, v1: v1, d1: d1, id1: ID1, v2: v2, d2: d2,
          id2: id2, robid: ROBID, imm: im, rd: rdx, pv: pv, ppc: last_ppc};
    sb.push_back(e);
  endtask

  task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
    instr_valid   = 1'b1;
    instr_in      = ins;
    instr_addr_in = pc;
    tick();
    instr_valid   = 1'b0;
  endtask

  logic [31:0] s2_ins [5] = '{32'h00100113, 32'h00208333, 32'h00300213, 32'h00400293, 32'h00700393};

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; instr_valid = 1'b0;
    instr_in = 32'd0; instr_addr_in = 32'd0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    reg_value1_in = 32'd0; reg_value2_in = 32'h22;
    has_dep1_in = 1'b0; has_dep2_in = 1'b1;
    v_rob_id1_in = ID1; v_rob_id2_in = ID2; rd_rob_id_in = ROBID;

    // Reset
    tick(); tick();
    check("rst_count", iq_count, 3'd0);
    check("rst_full", iq_full, 1'b0);
    check("rst_issued", instr_issued, 1'b0);
    check("rst_pvalid", predict_valid, 1'b0);
    check("rst_ppc", predict_pc, 32'd0);
    check("rst_imm", imm, 32'd0);
    check("rst_rd", rd, 5'd0);
    check("rst_instr", instr_out, 32'd0);
    rst = 1'b1;

    // ADDI x1,x0,5
    expect_issue(32'h00500093, 32'h0, 3'd0, 7'h13, 32'd0, 1'b0, 32'd5, 1'b0, 4'h0, 32'd5, 5'd1, 1'b0, 32'h0);
    push_one(32'h00500093, 32'h0);
    check("addi_count", iq_count, 3'd1);
    check("addi_reg_id2", reg_id2, 5'd5);
    tick();
    check("addi_issued", instr_issued, 1'b1);
    check("addi_pvalid", predict_valid, 1'b0);

    // Fill the queue behind rs_full; the fifth push is ignored
    rs_full = 1'b1;
    expect_issue(s2_ins[0], 32'h04, 3'd0, 7'h13, 32'd0, 1'b0, 32'd1, 1'b0, 4'h0, 32'd1, 5'd2, 1'b0, 32'h0);
    expect_issue(s2_ins[1], 32'h08, 3'd0, 7'h33, 32'd0, 1'b0, 32'h22, 1'b1, ID2, 32'd0, 5'd6, 1'b0, 32'h0);
    expect_issue(s2_ins[2], 32'h0C, 3'd0, 7'h13, 32'd0, 1'b0, 32'd3, 1'b0, 4'h0, 32'd3, 5'd4, 1'b0, 32'h0);
    expect_issue(s2_ins[3], 32'h10, 3'd0, 7'h13, 32'd0, 1'b0, 32'd4, 1'b0, 4'h0, 32'd4, 5'd5, 1'b0, 32'h0);
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr_in = s2_ins[i];
      instr_addr_in = 32'h04 + 32'(4 * i);
      tick();
      if (i == 3) begin
        check("full_flag", iq_full, 1'b1);
        check("full_count", iq_count, 3'd4);
      end
    end
    check("fifth_push_ignored", iq_count, 3'd4);
    instr_valid = 1'b0;
    rs_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_pulse", instr_issued, 1'b1);
    end
    check("drain_count", iq_count, 3'd0);

    // BEQ -8 predicted taken (backward), BEQ +8 not taken
    expect_issue(32'hFE000CE3, 32'h100, 3'd0, 7'h63, 32'd0, 1'b0, 32'h22, 1'b1, ID2, 32'hFFFFFFF8, 5'd0, 1'b1, 32'hF8);
    push_one(32'hFE000CE3, 32'h100);
    tick();
    check("beq_back_pvalid", predict_valid, 1'b1);
    check("beq_back_ppc", predict_pc, 32'hF8);
    tick();
    check("pvalid_one_cycle", predict_valid, 1'b0);
    expect_issue(32'h00000463, 32'h100, 3'd0, 7'h63, 32'd0, 1'b0, 32'h22, 1'b1, ID2, 32'd8, 5'd0, 1'b0, 32'h0);
    push_one(32'h00000463, 32'h100);
    tick();
    check("beq_fwd_issued", instr_issued, 1'b1);
    check("beq_fwd_pvalid", predict_valid, 1'b0);

    // JAL followed by two wrong-path ADDIs
    rs_full = 1'b1;
    expect_issue(32'h010000EF, 32'h20, 3'd0, 7'h6F, 32'd0, 1'b0, 32'd16, 1'b0, 4'h0, 32'd16, 5'd1, 1'b1, 32'h30);
    push_one(32'h010000EF, 32'h20);
    push_one(32'h00500093, 32'h24);
    push_one(32'h00100113, 32'h28);
    check("jal_queued", iq_count, 3'd3);
    rs_full = 1'b0;
    tick();
    check("jal_pvalid", predict_valid, 1'b1);
    check("jal_ppc", predict_pc, 32'h30);
    check("jal_squash", iq_count, 3'd0);
    tick(); tick();
    check("jal_squash_stays", iq_count, 3'd0);

    // Store issues through the LSB even while the RS is full; LSB full stalls it
    rs_full = 1'b1;
    expect_issue(32'h0020A423, 32'h40, 3'd2, 7'h23, 32'd0, 1'b0, 32'h22, 1'b1, ID2, 32'd8, 5'd0, 1'b0, 32'h0);
    push_one(32'h0020A423, 32'h40);
    tick();
    check("sw_rs_full_issue", instr_issued, 1'b1);
    rs_full = 1'b0;
    lsb_full = 1'b1;
    expect_issue(32'h0020A423, 32'h44, 3'd2, 7'h23, 32'd0, 1'b0, 32'h22, 1'b1, ID2, 32'd8, 5'd0, 1'b0, 32'h0);
    push_one(32'h0020A423, 32'h44);
    tick();
    check("sw_lsb_stall", instr_issued, 1'b0);
    check("sw_lsb_count", iq_count, 3'd1);
    lsb_full = 1'b0;
    tick();
    check("sw_lsb_release", instr_issued, 1'b1);

    // JALR waits for its base register
    has_dep1_in = 1'b1;
    expect_issue(32'h000100E7, 32'h50, 3'd0, 7'h67, 32'h1001, 1'b0, 32'd0, 1'b0, 4'h0, 32'd0, 5'd1, 1'b1, 32'h1000);
    push_one(32'h000100E7, 32'h50);
    tick();
    check("jalr_dep_stall", instr_issued, 1'b0);
    check("jalr_reg_id1", reg_id1, 5'd2);
    has_dep1_in = 1'b0;
    reg_value1_in = 32'h1001;
    tick();
    check("jalr_pvalid", predict_valid, 1'b1);
    check("jalr_ppc", predict_pc, 32'h1000);
    reg_value1_in = 32'd0;

    // RoB full blocks issue
    rob_full = 1'b1;
    expect_issue(32'h00200193, 32'h60, 3'd0, 7'h13, 32'd0, 1'b0, 32'd2, 1'b0, 4'h0, 32'd2, 5'd3, 1'b0, 32'h0);
    push_one(32'h00200193, 32'h60);
    tick();
    check("rob_full_stall", instr_issued, 1'b0);
    rob_full = 1'b0;
    tick();
    check("rob_full_release", instr_issued, 1'b1);

    // Flush with a concurrent push
    rs_full = 1'b1;
    push_one(32'h00100113, 32'h70);
    push_one(32'h00200193, 32'h74);
    push_one(32'h00300213, 32'h78);
    check("flush_pre_count", iq_count, 3'd3);
    flush = 1'b1;
    push_one(32'h00400293, 32'h7C);
    flush = 1'b0;
    check("flush_count", iq_count, 3'd0);
    check("flush_issued", instr_issued, 1'b0);
    rs_full = 1'b0;
    tick(); tick();
    check("flush_stays_empty", iq_count, 3'd0);

    // rdy low right after an issue freezes the pulse, outputs and count
    expect_issue(32'h00100113, 32'h80, 3'd0, 7'h13, 32'd0, 1'b0, 32'd1, 1'b0, 4'h0, 32'd1, 5'd2, 1'b0, 32'h0);
    push_one(32'h00100113, 32'h80);
    tick();
    rdy = 1'b0;
    instr_valid = 1'b1;
    instr_in = 32'h00200193;
    instr_addr_in = 32'h84;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("frz_issued", instr_issued, 1'b1);
      check("frz_count", iq_count, 3'd0);
      check("frz_imm", imm, 32'd1);
      check("frz_rd", rd, 5'd2);
    end
    expect_issue(32'h00200193, 32'h84, 3'd0, 7'h13, 32'd0, 1'b0, 32'd2, 1'b0, 4'h0, 32'd2, 5'd3, 1'b0, 32'h0);
    rdy = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("resume_count", iq_count, 3'd1);
    check("resume_no_issue", instr_issued, 1'b0);
    tick();
    check("resume_issue", instr_issued, 1'b1);

    tick(); tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/issue_decoder_q.md
Name: issue_decoder_q

Overview:
- Next-generation decode/issue stage between the Fetcher and the RS/LSB/RoB.
- Buffers fetched instructions in a parametrised FIFO and decodes the head entry.
- Issues one instruction per cycle, with per-unit stall rules (RS vs LSB) instead of a global stall.
- Makes a configurable static next-PC prediction, squashes queued wrong-path entries on a redirect, and supports a RoB flush.

Parameters:
- XLEN, 32, datapath/address width.
- ROB_ID_W, 4, RoB tag width.
- IQ_DEPTH, 4, instruction-queue entries (power of two, >=2).
- PRED_MODE, 0, 0 = branches predicted taken; 1 = backward-taken/forward-not-taken.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  RoB clear; discards queue and in-flight issue.
- instr_valid  in  1  fetcher presents an instruction.
- instr_in  in  32  instruction word.
- instr_addr_in  in  XLEN  instruction PC.
- iq_full  out  1  queue full; fetcher must hold.
- iq_count  out  log2(IQ_DEPTH)+1  occupancy.
- rob_full, rs_full, lsb_full  in  1 each  downstream full flags.
- reg_id1, reg_id2  out  5 each  head rs1/rs2 (combinational).
- reg_value1_in, reg_value2_in  in  XLEN each  regfile values.
- has_dep1_in, has_dep2_in  in  1 each  register renamed.
- v_rob_id1_in, v_rob_id2_in  in  ROB_ID_W each  producing tags.
- rd_rob_id_in  in  ROB_ID_W  tag allocated to this issue.
- instr_issued  out  1  one-cycle issue pulse.
- instr_out  out  32  issued instruction word.
- instr_addr_out  out  XLEN  issued instruction PC.
- op_out  out  3  issued funct3.
- instr_type_out  out  7  issued opcode.
- reg_value1_out, reg_value2_out  out  XLEN each  operand values.
- has_dep1_out, has_dep2_out  out  1 each  operand dependency flags.
- v_rob_id1_out, v_rob_id2_out  out  ROB_ID_W each  operand producer tags.
- rd_rob_id_out  out  ROB_ID_W  RoB tag of the issued instruction.
- imm  out  XLEN  issued immediate.
- rd  out  5  issued destination register.
- predict_valid  out  1  redirect pulse to fetcher.
- predict_pc  out  XLEN  redirect target.

Behaviour:
- Reset (rst==0 at posedge): queue empty, iq_count=0, every registered output 0.
- Priority per posedge: reset > !rdy (hold everything) > flush > normal operation.
- Push: when instr_valid && !iq_full, {instr_in, instr_addr_in} is enqueued. iq_full = (count==IQ_DEPTH); a same-cycle pop does not unblock a push when full.
- Immediates use the base ISA formats: LUI/AUIPC/JAL/JALR/B/LD/I/S; R-type imm = 0.
- has_rs2 is false for LUI, AUIPC, JAL, JALR, LD, I. has_rd is false for B and S.
- Issue condition (head valid) is all of:
  - !rob_full;
  - lsb_full==0 if opcode is LD or S, otherwise rs_full==0;
  - not (JALR && has_dep1_in).
- On issue (registered, 1-cycle latency):
  - instr_issued=1; head is popped.
  - rd = has_rd ? instr[11:7] : 0.
  - reg_value2_out/has_dep2_out/v_rob_id2_out = has_rs2 ? regfile values : {imm, 0, 0}.
  - rd_rob_id_out = rd_rob_id_in.
- No issue: instr_issued=0; all other outputs hold their values.
- Prediction target, computed on issue:
  - JAL: pc+imm.
  - JALR: rs1+imm with bit0 cleared.
  - B: taken target pc+imm if predicted taken, else pc+4. PRED_MODE=1 predicts taken iff imm[XLEN-1]==1.
  - Any other opcode: pc+4.
- Redirect: if target != pc+4, predict_valid=1 and predict_pc=target for one cycle.
  - Same edge: all remaining queue entries are discarded (count -> 0), and any same-cycle push is dropped.
  - Otherwise predict_valid=0; predict_pc holds.
- flush: queue emptied; instr_issued=0; predict_valid=0; the push in that cycle is dropped; data outputs hold.
- All address arithmetic wraps modulo 2^XLEN. FIFO pointers wrap modulo IQ_DEPTH.

Test Plan:
- Reset low for 2 cycles, then push ADDI x1,x0,5 (0x00500093) at pc 0x0, with regfile value1=0 and no deps:
  - next cycle instr_issued=1, imm=5, rd=1, reg_value2_out=5, has_dep2_out=0, predict_valid=0.
- Push 4 instrs with rs_full=1 (IQ_DEPTH=4):
  - iq_full=1 and iq_count=4; a fifth push is ignored.
  - Release rs_full: four consecutive issue pulses, in order.
- PRED_MODE=1:
  - BEQ -8 (0xFE000CE3) at 0x100 -> predict_valid=1, predict_pc=0xF8.
  - BEQ +8 (0x00000463) at 0x100 -> predict_valid=0.
- Queue JAL x1,+16 (0x010000EF) at 0x20 followed by two ADDIs:
  - predict_pc=0x30; both ADDIs discarded; iq_count=0 on the next cycle.
- Head JALR with has_dep1_in=1 -> no issue. Drop has_dep1_in with value 0x1001 and imm 0 -> issue with predict_pc=0x1000.
- Queue 3 entries, assert flush together with instr_valid -> iq_count=0, instr_issued=0. rdy=0 mid-stream -> all outputs and count frozen.
